// File: rtl/mem_arbiter_pkg.sv
// Shared types and lane helpers for the unified-memory arbiter.
// ldst_byteen is the same lane decode the datapath load/store unit uses.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    localparam int BYTEEN_W     = 4;
    localparam int LDST_WIDTH_W = 2;

    localparam logic [1:0] LDST_BYTE = 2'b00;
    localparam logic [1:0] LDST_HALF = 2'b01;
    localparam logic [1:0] LDST_WORD = 2'b10;

    function automatic logic [BYTEEN_W-1:0] ldst_byteen(input logic [1:0] width,
                                                        input logic [1:0] addr_lo);
        logic [BYTEEN_W-1:0] be_s;
        case (width)
            LDST_BYTE: be_s = 4'b0001 << addr_lo;
            LDST_HALF: be_s = 4'b0011 << {addr_lo[1], 1'b0};
            default:   be_s = 4'b1111;
        endcase
        return be_s;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Datapath-facing split memory ports plus the single-ported RAM bus.
// slave is the arbiter's view; master is the datapath/RAM environment.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic                    imem_ren;
    logic [31:0]             imem_addr;
    logic [31:0]             imem_load;
    logic                    ihit;
    logic                    dmem_ren;
    logic                    dmem_wen;
    logic [31:0]             dmem_addr;
    logic [LDST_WIDTH_W-1:0] dmem_width;
    logic [31:0]             dmem_store;
    logic [31:0]             dmem_load;
    logic                    dhit;
    logic                    ifault;
    logic                    dfault;
    logic                    ram_ren;
    logic                    ram_wen;
    logic [ADDR_W-1:0]       ram_addr;
    logic [BYTEEN_W-1:0]     ram_byteen;
    logic [31:0]             ram_store;
    logic [31:0]             ram_load;
    logic                    ram_ready;

    modport slave (
        input  imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_width,
               dmem_store, ram_load, ram_ready,
        output imem_load, ihit, dmem_load, dhit, ifault, dfault,
               ram_ren, ram_wen, ram_addr, ram_byteen, ram_store
    );

    modport master (
        output imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_width,
               dmem_store, ram_load, ram_ready,
        input  imem_load, ihit, dmem_load, dhit, ifault, dfault,
               ram_ren, ram_wen, ram_addr, ram_byteen, ram_store
    );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts cycles spent in an access state and flags expiry
// on the last permitted cycle. TIMEOUT_CYCLES of 0 disables it.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic nrst,
    input  logic active,
    output logic timeout
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_r;
    logic             expire_s;

    // Expiry decode on the final cycle of the allowed window
    always_comb begin
        expire_s = 1'b0;
        if (TIMEOUT_CYCLES == 0) begin
            expire_s = 1'b0;
        end else begin
            expire_s = active && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    end

    // Cycle counter, held at zero outside an access so each entry starts fresh
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_r <= '0;
        end else if (!active || expire_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign timeout = expire_s;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between split I/D memory ports and a single-ported unified RAM.
// Optional one-entry fetch buffer is enabled with `define MEM_ARB_FETCH_BUF_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32
) (
    input logic           clk,
    input logic           nrst,
    mem_arbiter_if.slave  bus
);
    arb_state_t          state_r;
    arb_state_t          next_s;
    logic                dreq_s;
    logic                grant_i_s;
    logic                grant_d_s;
    logic                ihit_ram_s;
    logic                dhit_s;
    logic                ifault_s;
    logic                dfault_s;
    logic                timeout_s;
    logic                buf_hit_s;
    logic [31:0]         buf_data_s;
    logic [31:0]         imem_load_s;
    logic                ram_ren_r;
    logic                ram_wen_r;
    logic [31:0]         acc_addr_r;
    logic [BYTEEN_W-1:0] ram_byteen_r;
    logic [31:0]         ram_store_r;
    logic                unused_s;

    assign dreq_s   = bus.dmem_ren | bus.dmem_wen;
    assign unused_s = ^bus.imem_addr[1:0];

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .nrst    (nrst),
        .active  (state_r != IDLE),
        .timeout (timeout_s)
    );

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Arbitration, completion and abort decode; completion beats timeout
    always_comb begin
        next_s     = state_r;
        grant_i_s  = 1'b0;
        grant_d_s  = 1'b0;
        ihit_ram_s = 1'b0;
        dhit_s     = 1'b0;
        ifault_s   = 1'b0;
        dfault_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (dreq_s) begin
                    next_s    = DACC;
                    grant_d_s = 1'b1;
                end else if (bus.imem_ren && !buf_hit_s) begin
                    next_s    = IACC;
                    grant_i_s = 1'b1;
                end else begin
                    next_s = IDLE;
                end
            end
            IACC: begin
                if (bus.ram_ready) begin
                    ihit_ram_s = 1'b1;
                    next_s     = IDLE;
                end else if (timeout_s) begin
                    ifault_s = 1'b1;
                    next_s   = IDLE;
                end else begin
                    next_s = IACC;
                end
            end
            DACC: begin
                if (bus.ram_ready) begin
                    dhit_s = 1'b1;
                    next_s = IDLE;
                end else if (timeout_s) begin
                    dfault_s = 1'b1;
                    next_s   = IDLE;
                end else begin
                    next_s = DACC;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // RAM command register: loaded at grant, strobes dropped when the access ends
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ram_ren_r    <= 1'b0;
            ram_wen_r    <= 1'b0;
            acc_addr_r   <= 32'h0000_0000;
            ram_byteen_r <= 4'b0000;
            ram_store_r  <= 32'h0000_0000;
        end else if (grant_d_s) begin
            // a simultaneous read+write request is handled as the store
            ram_ren_r    <= ~bus.dmem_wen;
            ram_wen_r    <= bus.dmem_wen;
            acc_addr_r   <= {bus.dmem_addr[31:2], 2'b00};
            ram_byteen_r <= bus.dmem_wen ? ldst_byteen(bus.dmem_width[1:0], bus.dmem_addr[1:0])
                                         : 4'b1111;
            ram_store_r  <= bus.dmem_store;
        end else if (grant_i_s) begin
            ram_ren_r    <= 1'b1;
            ram_wen_r    <= 1'b0;
            acc_addr_r   <= {bus.imem_addr[31:2], 2'b00};
            ram_byteen_r <= 4'b1111;
            ram_store_r  <= bus.dmem_store;
        end else if (ihit_ram_s || dhit_s || ifault_s || dfault_s) begin
            ram_ren_r <= 1'b0;
            ram_wen_r <= 1'b0;
        end else begin
            ram_ren_r <= ram_ren_r;
            ram_wen_r <= ram_wen_r;
        end
    end

`ifdef MEM_ARB_FETCH_BUF_EN
    logic        buf_valid_r;
    logic [29:0] buf_addr_r;
    logic [31:0] buf_data_r;

    // Buffer lookup, only when the RAM path would otherwise be granted a fetch
    always_comb begin
        buf_hit_s = 1'b0;
        if ((state_r == IDLE) && bus.imem_ren && !dreq_s && buf_valid_r &&
            (bus.imem_addr[31:2] == buf_addr_r)) begin
            buf_hit_s = 1'b1;
        end else begin
            buf_hit_s = 1'b0;
        end
    end

    // Buffer fill on RAM fetch completion; drop on aliasing store or fetch abort
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            buf_valid_r <= 1'b0;
            buf_addr_r  <= 30'h0;
            buf_data_r  <= 32'h0000_0000;
        end else if (ihit_ram_s) begin
            buf_valid_r <= 1'b1;
            buf_addr_r  <= acc_addr_r[31:2];
            buf_data_r  <= bus.ram_load;
        end else if (ifault_s ||
                     (grant_d_s && bus.dmem_wen && (bus.dmem_addr[31:2] == buf_addr_r))) begin
            buf_valid_r <= 1'b0;
        end else begin
            buf_valid_r <= buf_valid_r;
        end
    end

    assign buf_data_s = buf_data_r;
`else
    assign buf_hit_s  = 1'b0;
    assign buf_data_s = 32'h0000_0000;
`endif

    // Fetch data mux; zero whenever no hit is signalled
    always_comb begin
        imem_load_s = 32'h0000_0000;
        if (ihit_ram_s) begin
            imem_load_s = bus.ram_load;
        end else if (buf_hit_s) begin
            imem_load_s = buf_data_s;
        end else begin
            imem_load_s = 32'h0000_0000;
        end
    end

    assign bus.ihit       = ihit_ram_s | buf_hit_s;
    assign bus.imem_load  = imem_load_s;
    assign bus.dhit       = dhit_s;
    assign bus.dmem_load  = dhit_s ? bus.ram_load : 32'h0000_0000;
    assign bus.ifault     = ifault_s;
    assign bus.dfault     = dfault_s;
    assign bus.ram_ren    = ram_ren_r;
    assign bus.ram_wen    = ram_wen_r;
    assign bus.ram_addr   = ADDR_W'(acc_addr_r);
    assign bus.ram_byteen = ram_byteen_r;
    assign bus.ram_store  = ram_store_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle watchdog.
// Buffer expectations follow MEM_ARB_FETCH_BUF_EN when it is defined.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TO = 4;
`ifdef MEM_ARB_FETCH_BUF_EN
    localparam logic BUF_EN = 1'b1;
`else
    localparam logic BUF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic nrst;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .ADDR_W         (32)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] width,
                            input logic [31:0] data, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic also_ren);
        bus.dmem_wen   = 1'b1;
        bus.dmem_ren   = also_ren;
        bus.dmem_addr  = addr;
        bus.dmem_width = width;
        bus.dmem_store = data;
        step();
        chk({tag, "_wen"},    32'(bus.ram_wen), 32'd1);
        chk({tag, "_ren"},    32'(bus.ram_ren), 32'd0);
        chk({tag, "_addr"},   bus.ram_addr, exp_addr);
        chk({tag, "_byteen"}, 32'(bus.ram_byteen), 32'(exp_be));
        chk({tag, "_store"},  bus.ram_store, data);
        bus.ram_ready = 1'b1;
        settle();
        chk({tag, "_dhit"}, 32'(bus.dhit), 32'd1);
        bus.dmem_wen = 1'b0;
        bus.dmem_ren = 1'b0;
        step();
        bus.ram_ready = 1'b0;
        settle();
        chk({tag, "_wen_drop"}, 32'(bus.ram_wen), 32'd0);
    endtask

    initial begin
        nrst           = 1'b0;
        bus.imem_ren   = 1'b0;
        bus.imem_addr  = 32'h0;
        bus.dmem_ren   = 1'b0;
        bus.dmem_wen   = 1'b0;
        bus.dmem_addr  = 32'h0;
        bus.dmem_width = 2'b00;
        bus.dmem_store = 32'h0;
        bus.ram_load   = 32'h0;
        bus.ram_ready  = 1'b0;
        #2;
        chk("rst_ram_ren",  32'(bus.ram_ren), 32'd0);
        chk("rst_ram_wen",  32'(bus.ram_wen), 32'd0);
        chk("rst_ram_addr", bus.ram_addr, 32'h0);
        chk("rst_byteen",   32'(bus.ram_byteen), 32'd0);
        chk("rst_store",    bus.ram_store, 32'h0);
        chk("rst_hits",     32'({bus.ihit, bus.dhit, bus.ifault, bus.dfault}), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        step();

        // ready while idle is ignored
        bus.ram_ready = 1'b1;
        settle();
        chk("idle_ready_hits", 32'({bus.ihit, bus.dhit}), 32'd0);
        bus.ram_ready = 1'b0;
        step();

        // plain fetch, ready on the third access cycle
        bus.imem_ren  = 1'b1;
        bus.imem_addr = 32'h0000_0100;
        settle();
        chk("f_idle_ren", 32'(bus.ram_ren), 32'd0);
        step();
        chk("f_ren",    32'(bus.ram_ren), 32'd1);
        chk("f_addr",   bus.ram_addr, 32'h0000_0100);
        chk("f_byteen", 32'(bus.ram_byteen), 32'hF);
        chk("f_c1_ihit", 32'(bus.ihit), 32'd0);
        step();
        chk("f_c2_ihit", 32'(bus.ihit), 32'd0);
        step();
        bus.ram_ready = 1'b1;
        bus.ram_load  = 32'h0000_0013;
        settle();
        chk("f_ihit",  32'(bus.ihit), 32'd1);
        chk("f_load",  bus.imem_load, 32'h0000_0013);
        chk("f_fault", 32'(bus.ifault), 32'd0);
        bus.imem_ren = 1'b0;
        step();
        bus.ram_ready = 1'b0;
        settle();
        chk("f_ihit_drop", 32'(bus.ihit), 32'd0);
        chk("f_ren_drop",  32'(bus.ram_ren), 32'd0);

        // simultaneous data read and fetch: data first, one idle turnaround
        bus.dmem_ren   = 1'b1;
        bus.dmem_addr  = 32'h0000_0200;
        bus.dmem_width = 2'b10;
        bus.imem_ren   = 1'b1;
        bus.imem_addr  = 32'h0000_0104;
        step();
        chk("s_d_ren",  32'(bus.ram_ren), 32'd1);
        chk("s_d_wen",  32'(bus.ram_wen), 32'd0);
        chk("s_d_addr", bus.ram_addr, 32'h0000_0200);
        bus.ram_ready = 1'b1;
        bus.ram_load  = 32'hDEAD_BEEF;
        settle();
        chk("s_dhit",  32'(bus.dhit), 32'd1);
        chk("s_ihit0", 32'(bus.ihit), 32'd0);
        chk("s_dload", bus.dmem_load, 32'hDEAD_BEEF);
        bus.dmem_ren = 1'b0;
        step();
        chk("s_turn_ren",  32'(bus.ram_ren), 32'd0);
        chk("s_turn_ihit", 32'(bus.ihit), 32'd0);
        step();
        chk("s_i_ren",  32'(bus.ram_ren), 32'd1);
        chk("s_i_addr", bus.ram_addr, 32'h0000_0104);
        bus.ram_load = 32'h1111_1111;
        settle();
        chk("s_ihit",  32'(bus.ihit), 32'd1);
        chk("s_iload", bus.imem_load, 32'h1111_1111);
        bus.imem_ren = 1'b0;
        step();
        bus.ram_ready = 1'b0;

        // stores: byte (with read also raised), half, word
        do_store("st_b", 32'h0000_0203, 2'b00, 32'hAB00_0000, 32'h0000_0200, 4'b1000, 1'b1);
        do_store("st_h", 32'h0000_0202, 2'b01, 32'hCDEF_0000, 32'h0000_0200, 4'b1100, 1'b0);
        do_store("st_w", 32'h0000_0200, 2'b10, 32'h1234_5678, 32'h0000_0200, 4'b1111, 1'b0);

        // ready on the last watchdog cycle: completion wins
        bus.imem_ren  = 1'b1;
        bus.imem_addr = 32'h0000_0180;
        step();
        step();
        step();
        step();
        bus.ram_ready = 1'b1;
        bus.ram_load  = 32'h0000_0077;
        settle();
        chk("tb_ihit",  32'(bus.ihit), 32'd1);
        chk("tb_fault", 32'(bus.ifault), 32'd0);
        bus.imem_ren = 1'b0;
        step();
        bus.ram_ready = 1'b0;

        // fetch timeout
        bus.imem_ren  = 1'b1;
        bus.imem_addr = 32'h0000_0300;
        step();
        chk("to_c1_fault", 32'(bus.ifault), 32'd0);
        step();
        step();
        chk("to_c3_fault", 32'(bus.ifault), 32'd0);
        step();
        chk("to_fault", 32'(bus.ifault), 32'd1);
        chk("to_ihit",  32'(bus.ihit), 32'd0);
        chk("to_dflt",  32'(bus.dfault), 32'd0);
        bus.imem_ren = 1'b0;
        step();
        chk("to_ren_drop",   32'(bus.ram_ren), 32'd0);
        chk("to_fault_drop", 32'(bus.ifault), 32'd0);

        // reset in the middle of a store
        bus.dmem_wen   = 1'b1;
        bus.dmem_addr  = 32'h0000_0400;
        bus.dmem_width = 2'b10;
        bus.dmem_store = 32'h55AA_55AA;
        step();
        chk("rm_wen", 32'(bus.ram_wen), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        chk("rm_wen_async", 32'(bus.ram_wen), 32'd0);
        chk("rm_addr",      bus.ram_addr, 32'h0);
        chk("rm_store",     bus.ram_store, 32'h0);
        chk("rm_byteen",    32'(bus.ram_byteen), 32'd0);
        bus.dmem_wen  = 1'b0;
        bus.ram_ready = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        step();
        chk("rm_no_dhit", 32'(bus.dhit), 32'd0);
        chk("rm_wen_off", 32'(bus.ram_wen), 32'd0);
        bus.ram_ready = 1'b0;
        step();

        // fetch-buffer behaviour (RAM path expected when the buffer is absent)
        bus.imem_ren  = 1'b1;
        bus.imem_addr = 32'h0000_0100;
        settle();
        chk("fb_cold_ihit", 32'(bus.ihit), 32'd0);
        step();
        chk("fb_cold_ren", 32'(bus.ram_ren), 32'd1);
        bus.ram_ready = 1'b1;
        bus.ram_load  = 32'h0000_0013;
        settle();
        chk("fb_cold_hit", 32'(bus.ihit), 32'd1);
        bus.imem_ren = 1'b0;
        step();
        bus.ram_ready = 1'b0;
        bus.ram_load  = 32'h0;
        bus.imem_ren  = 1'b1;
        settle();
        chk("fb_re_ihit", 32'(bus.ihit), 32'(BUF_EN));
        chk("fb_re_load", bus.imem_load, BUF_EN ? 32'h0000_0013 : 32'h0);
        step();
        bus.imem_ren = 1'b0;
        settle();
        chk("fb_re_ren", 32'(bus.ram_ren), BUF_EN ? 32'd0 : 32'd1);
        bus.ram_ready = 1'b1;
        bus.ram_load  = 32'h0000_0013;
        step();
        bus.ram_ready = 1'b0;
        settle();
        do_store("fb_st", 32'h0000_0100, 2'b10, 32'h0000_0093, 32'h0000_0100, 4'b1111, 1'b0);
        bus.imem_ren  = 1'b1;
        bus.imem_addr = 32'h0000_0100;
        settle();
        chk("fb_inv_ihit", 32'(bus.ihit), 32'd0);
        step();
        chk("fb_inv_ren", 32'(bus.ram_ren), 32'd1);
        bus.ram_ready = 1'b1;
        bus.ram_load  = 32'h0000_0093;
        settle();
        chk("fb_inv_hit",  32'(bus.ihit), 32'd1);
        chk("fb_inv_load", bus.imem_load, 32'h0000_0093);
        bus.imem_ren = 1'b0;
        step();
        bus.ram_ready = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
